add_roundkey_seq: RTL
=====================

# add_roundkey_seq

Sequential, parametrised AddRoundKey engine for the AES encryption datapath. It accepts a state block, a round key and a round tag over a valid/ready handshake. It XORs the block with the key one SLICE_W-bit slice per cycle, so the XOR width is decoupled from the block width. It returns the result over a second valid/ready handshake, and sits between MixColumns and the next round's SubBytes in the round loop.

## Interface
- BLOCK_W, default 128: state/key width in bits; must be a multiple of SLICE_W.
- SLICE_W, default 32: bits XORed per cycle; legal values 8, 16, 32, 64, 128.
- ROUND_W, default 4: width of the round tag carried alongside the block.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  block, key and tag presented.
- in_ready  output  1  engine can accept a block.
- data_in  input  BLOCK_W  AES state; bits [BLOCK_W-1 -: 8] are byte 0.
- key_in  input  BLOCK_W  round key, same byte order.
- round_in  input  ROUND_W  round tag.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- data_out  output  BLOCK_W  data_in XOR key_in.
- round_out  output  ROUND_W  tag captured with the block.
- busy  output  1  high in XOR or DONE.

## Operation
- NS = BLOCK_W/SLICE_W. The slice counter is $clog2(NS) bits wide, with a minimum width of 1.
- FSM states are IDLE, XOR and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture data_in, key_in and round_in into internal registers, clear the slice counter and go to XOR.
- XOR:
  - Each cycle, state slice k ^= key slice k. Slice 0 is the MS slice, bits [BLOCK_W-1 -: SLICE_W].
  - The counter increments each cycle. After slice NS-1 the FSM goes to DONE.
  - When NS = 1, XOR lasts exactly one cycle.
- DONE:
  - out_valid = 1. data_out and round_out hold the registered result.
  - On out_ready, go to IDLE. data_out and round_out keep their last values until the next result.
- Inputs are ignored outside IDLE. in_ready = 0 there, and no input is captured.
- The key register is not cleared after use.
- Reset values:
  - FSM = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - data_out = 0, round_out = 0, slice counter = 0.
  - Internal key register = 0.
- Reset mid-operation (XOR or DONE) abandons the block. The engine is in IDLE the next cycle with no out_valid pulse.
- Throughput is one block per NS+2 cycles with out_ready tied high. Input and output are not overlapped.

## Timing
- in_valid and in_ready are both high at edge T: the block is captured at T.
- Slices are processed on edges T+1 … T+NS.
- out_valid is high from after edge T+NS until the edge where out_ready = 1. The earliest such edge is T+NS+1.
- in_ready returns high in the cycle after the output handshake. There is no combinational path from out_ready to in_ready.
- All outputs are registered.

## Configuration
- ADD_RK_BYPASS_EN defined:
  - Adds input port bypass_in (1 bit), sampled with data_in.
  - When the captured bypass bit is 1, the XOR state is skipped: IDLE goes straight to DONE, with data_out = data_in and round_out = round_in.
  - Latency in that case is 1 cycle to out_valid.
- ADD_RK_BYPASS_EN undefined:
  - No bypass_in port, and the XOR state is always taken.

## Structure
- A shared package aes_pkg holds:
  - The FSM state enum ark_state_t (IDLE, XOR, DONE).
  - AES_BLOCK_W = 128.
  - The FIPS-197 test constants used by the bench.
- One sub-module, ark_slice_xor: combinational SLICE_W-bit XOR. It is instantiated once and indexed by the slice counter.

## Test plan
- Default params, data_in = 3243f6a8885a308d313198a2e0370734, key_in = 2b7e151628aed2a6abf7158809cf4f3c, round_in = 0, out_ready = 1:
  - data_out = 193de3bea0f4e22b9ac68d2ae9f84808 and round_out = 0.
  - out_valid rises 5 cycles after capture.
- SLICE_W = 8 and SLICE_W = 128, same vectors:
  - Identical data_out.
  - Latency 17 and 2 cycles respectively.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid.
  - out_valid stays high, data_out is stable, in_ready stays 0.
  - A second in_valid presented during this window is not captured.
- Reset mid-block:
  - Assert rst in the 2nd XOR cycle.
  - Next cycle: in_ready = 1, out_valid = 0, data_out = 0.
  - A new block then completes correctly.
- Back-to-back, with in_valid and out_ready held high, data_in = all-ones and key_in = all-ones, then data_in = 0 and key_in = 0:
  - Two results, both 0.
  - Blocks are accepted every NS+2 cycles.
- With ADD_RK_BYPASS_EN, bypass_in = 1 and round_in = 9:
  - data_out = data_in and round_out = 9.
  - out_valid is high one cycle after capture.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: AddRoundKey FSM state encoding, block width and
// FIPS-197 reference vectors.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XOR  = 2'd1,
        DONE = 2'd2
    } ark_state_t;

    // FIPS-197 Appendix B: input block, cipher key, state after initial AddRoundKey
    localparam logic [AES_BLOCK_W-1:0] FIPS_B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [AES_BLOCK_W-1:0] FIPS_B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [AES_BLOCK_W-1:0] FIPS_B_ARK = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    // FIPS-197 Appendix C.1: input block, cipher key, state after initial AddRoundKey
    localparam logic [AES_BLOCK_W-1:0] FIPS_C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [AES_BLOCK_W-1:0] FIPS_C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [AES_BLOCK_W-1:0] FIPS_C_ARK = 128'h00102030405060708090a0b0c0d0e0f0;

endpackage

// File: rtl/ark_slice_xor.sv
// One SLICE_W-bit slice of AddRoundKey: state slice XOR key slice.
module ark_slice_xor #(
    parameter int unsigned SLICE_W = 32
) (
    input  logic [SLICE_W-1:0] i_state,
    input  logic [SLICE_W-1:0] i_key,
    output logic [SLICE_W-1:0] o_state
);

    assign o_state = i_state ^ i_key;

endmodule

// File: rtl/add_roundkey_seq.sv
// Sequential AddRoundKey engine: captures a block, key and round tag, XORs one
// SLICE_W-bit slice per cycle (slice 0 = most significant) and returns the
// result over a valid/ready handshake.
// Optional feature: define ADD_RK_BYPASS_EN to add bypass_in, which skips the
// XOR phase and returns the captured block and tag unchanged.
module add_roundkey_seq
    import aes_pkg::*;
#(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned SLICE_W = 32,
    parameter int unsigned ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic [BLOCK_W-1:0] key_in,
    input  logic [ROUND_W-1:0] round_in,
`ifdef ADD_RK_BYPASS_EN
    input  logic               bypass_in,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] data_out,
    output logic [ROUND_W-1:0] round_out,
    output logic               busy
);

    localparam int unsigned NS    = BLOCK_W / SLICE_W;
    localparam int unsigned CNT_W = (NS > 1) ? $clog2(NS) : 1;

    ark_state_t         r_state;
    ark_state_t         w_next;
    logic [BLOCK_W-1:0] r_data;
    logic [BLOCK_W-1:0] r_key;
    logic [BLOCK_W-1:0] r_dout;
    logic [ROUND_W-1:0] r_round;
    logic [ROUND_W-1:0] r_rout;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_bypass;
    logic               w_last;
    logic [SLICE_W-1:0] w_data_slice;
    logic [SLICE_W-1:0] w_key_slice;
    logic [SLICE_W-1:0] w_xor_slice;
    logic [BLOCK_W-1:0] w_data_upd;

`ifdef ADD_RK_BYPASS_EN
    assign w_bypass = bypass_in;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_W'(NS - 1));

    // Next-state logic for the IDLE -> XOR -> DONE block cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = w_bypass ? DONE : XOR;
            XOR:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Handshake/status flags registered from the next state so no output is combinational
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == IDLE);
            r_out_valid <= (w_next == DONE);
            r_busy      <= (w_next != IDLE);
        end
    end

    // Select the slice addressed by the counter (slice 0 is the MS slice)
    always_comb begin
        w_data_slice = '0;
        w_key_slice  = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_data_slice = r_data[BLOCK_W-1-k*SLICE_W -: SLICE_W];
                w_key_slice  = r_key[BLOCK_W-1-k*SLICE_W -: SLICE_W];
            end
        end
    end

    ark_slice_xor #(
        .SLICE_W(SLICE_W)
    ) u_slice_xor (
        .i_state(w_data_slice),
        .i_key  (w_key_slice),
        .o_state(w_xor_slice)
    );

    // Write the XORed slice back into its position in the state block
    always_comb begin
        w_data_upd = r_data;
        for (int unsigned k = 0; k < NS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_data_upd[BLOCK_W-1-k*SLICE_W -: SLICE_W] = w_xor_slice;
            end
        end
    end

    // Datapath: capture, per-slice update, and result registers that only change on a new result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_key   <= '0;
            r_round <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_rout  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= data_in;
                        r_key   <= key_in;
                        r_round <= round_in;
                        r_cnt   <= '0;
                        if (w_bypass) begin
                            r_dout <= data_in;
                            r_rout <= round_in;
                        end
                    end
                end
                XOR: begin
                    r_data <= w_data_upd;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_dout <= w_data_upd;
                        r_rout <= r_round;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign data_out  = r_dout;
    assign round_out = r_rout;

endmodule
